// File: rtl/qdriip_arb_pkg.sv
// Shared types and helpers for the QDRII+ user-interface arbiter.
// Holds the default parameter values, the requester tag type and the
// cyclic round-robin search used by both command channels.

package qdriip_arb_pkg;

    localparam int MAX_REQ             = 4;
    localparam int DEF_NUM_REQ         = 2;
    localparam int DEF_ADDR_WIDTH      = 22;
    localparam int DEF_DATA_WIDTH      = 72;
    localparam int DEF_BW_WIDTH        = 8;
    localparam int DEF_MAX_OUTSTANDING = 16;

    // Tags are sized for the largest supported requester count so that
    // one type serves every configuration.
    localparam int TAG_WIDTH = $clog2(MAX_REQ);
    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic hit;
        tag_t idx;
    } pick_t;

    // Returns the first asserted valid at or after ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input tag_t               ptr,
                                      input int                 n);
        pick_t p;
        int    c;
        p = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            if (off < n) begin
                c = int'(ptr) + off;
                if (c >= n) begin
                    c = c - n;
                end
                if (!p.hit && valid[c[1:0]]) begin
                    p.hit = 1'b1;
                    p.idx = tag_t'(c);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/qdriip_rr_arbiter.sv
// Round-robin arbiter for one command channel. The grant is combinational
// from the current valids; the priority pointer moves past the winner on
// every grant, since a grant always completes a transfer.

module qdriip_rr_arbiter
    import qdriip_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output tag_t               o_index
);

    localparam tag_t LAST = tag_t'(NUM_REQ - 1);

    logic [MAX_REQ-1:0] w_valid_ext;
    pick_t              w_pick;
    logic               w_hit;
    tag_t               r_ptr;

    // Widen the request vector to the fixed width the search function uses.
    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_REQ-1:0]   = i_valid;
    end

    assign w_pick  = rr_pick(w_valid_ext, r_ptr, NUM_REQ);
    assign w_hit   = w_pick.hit & i_enable;
    assign o_index = w_pick.idx;

    // Decode the winning index into a one-hot grant, or all zero when idle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = w_hit && (w_pick.idx == tag_t'(i));
        end
    end

    // Advance priority to the requester after the one just served.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= (w_pick.idx == LAST) ? '0 : w_pick.idx + tag_t'(1);
        end
    end

endmodule

// File: rtl/qdriip_ui_arbiter.sv
// Shares one QDRII+ memory-controller user interface among several
// requesters. Writes and reads are arbitrated independently; each read's
// requester index is queued so returning data can be routed in order.

module qdriip_ui_arbiter
    import qdriip_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BW_WIDTH        = DEF_BW_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_init_calib_complete,
    input  logic [NUM_REQ-1:0]              i_req_wr_valid,
    output logic [NUM_REQ-1:0]              o_req_wr_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
    input  logic [NUM_REQ*BW_WIDTH-1:0]     i_req_wr_bw_n,
    input  logic [NUM_REQ-1:0]              i_req_rd_valid,
    output logic [NUM_REQ-1:0]              o_req_rd_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_rd_addr,
    output logic [NUM_REQ-1:0]              o_rsp_rd_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_rd_data,
    output logic                            o_app_wr_cmd,
    output logic [ADDR_WIDTH-1:0]           o_app_wr_addr,
    output logic [DATA_WIDTH-1:0]           o_app_wr_data,
    output logic [BW_WIDTH-1:0]             o_app_wr_bw_n,
    output logic                            o_app_rd_cmd,
    output logic [ADDR_WIDTH-1:0]           o_app_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_app_rd_data,
    input  logic                            i_app_rd_valid,
    output logic                            o_rd_underflow_err,
    output logic [$clog2(MAX_OUTSTANDING):0] o_rd_outstanding
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REQ-1:0]    w_wr_grant;
    logic [NUM_REQ-1:0]    w_rd_grant;
    tag_t                  w_wr_idx;
    tag_t                  w_rd_idx;
    logic                  w_wr_xfer;
    logic                  w_rd_xfer;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    tag_t                  w_head;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [BW_WIDTH-1:0]   w_wr_bw_n;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    tag_t                  r_tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_fifo_wr_ptr;
    logic [PTR_W-1:0]      r_fifo_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_app_wr_cmd;
    logic [ADDR_WIDTH-1:0] r_app_wr_addr;
    logic [DATA_WIDTH-1:0] r_app_wr_data;
    logic [BW_WIDTH-1:0]   r_app_wr_bw_n;
    logic                  r_app_rd_cmd;
    logic [ADDR_WIDTH-1:0] r_app_rd_addr;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_underflow;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    qdriip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_init_calib_complete),
        .i_valid  (i_req_wr_valid),
        .o_grant  (w_wr_grant),
        .o_index  (w_wr_idx)
    );

    qdriip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_init_calib_complete & ~w_full),
        .i_valid  (i_req_rd_valid),
        .o_grant  (w_rd_grant),
        .o_index  (w_rd_idx)
    );

    assign o_req_wr_ready = w_wr_grant;
    assign o_req_rd_ready = w_rd_grant;
    assign w_wr_xfer      = |w_wr_grant;
    assign w_rd_xfer      = |w_rd_grant;
    assign w_pop          = i_app_rd_valid & ~w_empty;
    assign w_head         = r_tag_mem[r_fifo_rd_ptr];

    // Select the winning requester's payload on each channel.
    always_comb begin
        w_wr_addr = i_req_wr_addr[int'(w_wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_data = i_req_wr_data[int'(w_wr_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_wr_bw_n = i_req_wr_bw_n[int'(w_wr_idx)*BW_WIDTH +: BW_WIDTH];
        w_rd_addr = i_req_rd_addr[int'(w_rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Register the write command; idle cycles mask all bytes and hold addr/data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_app_wr_cmd  <= 1'b0;
            r_app_wr_addr <= '0;
            r_app_wr_data <= '0;
            r_app_wr_bw_n <= '1;
        end else if (w_wr_xfer) begin
            r_app_wr_cmd  <= 1'b1;
            r_app_wr_addr <= w_wr_addr;
            r_app_wr_data <= w_wr_data;
            r_app_wr_bw_n <= w_wr_bw_n;
        end else begin
            r_app_wr_cmd  <= 1'b0;
            r_app_wr_bw_n <= '1;
        end
    end

    // Register the read command; the address holds while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_app_rd_cmd  <= 1'b0;
            r_app_rd_addr <= '0;
        end else begin
            r_app_rd_cmd <= w_rd_xfer;
            if (w_rd_xfer) begin
                r_app_rd_addr <= w_rd_addr;
            end
        end
    end

    // Tag storage; stale entries after a flush are never read.
    always_ff @(posedge i_clk) begin
        if (w_rd_xfer) begin
            r_tag_mem[r_fifo_wr_ptr] <= w_rd_idx;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop together leave it unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fifo_wr_ptr <= '0;
            r_fifo_rd_ptr <= '0;
            r_count       <= '0;
        end else begin
            if (w_rd_xfer) begin
                r_fifo_wr_ptr <= r_fifo_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_fifo_rd_ptr <= r_fifo_rd_ptr + PTR_W'(1);
            end
            case ({w_rd_xfer, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Route returned data to the requester at the FIFO head; flag orphan returns.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rsp_valid[i] <= w_pop && (w_head == tag_t'(i));
            end
            if (w_pop) begin
                r_rsp_data <= i_app_rd_data;
            end
            if (i_app_rd_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_app_wr_cmd       = r_app_wr_cmd;
    assign o_app_wr_addr      = r_app_wr_addr;
    assign o_app_wr_data      = r_app_wr_data;
    assign o_app_wr_bw_n      = r_app_wr_bw_n;
    assign o_app_rd_cmd       = r_app_rd_cmd;
    assign o_app_rd_addr      = r_app_rd_addr;
    assign o_rsp_rd_valid     = r_rsp_valid;
    assign o_rsp_rd_data      = r_rsp_data;
    assign o_rd_underflow_err = r_underflow;
    assign o_rd_outstanding   = r_count;

endmodule

// File: tb/tb_qdriip_ui_arbiter.sv
// Directed bench for the QDRII+ UI arbiter with two requesters.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.

module tb_qdriip_ui_arbiter;

    localparam int NR = 2;
    localparam int AW = 22;
    localparam int DW = 72;
    localparam int BW = 8;
    localparam int MO = 16;

    logic              clk;
    logic              rst;
    logic              calib;
    logic [NR-1:0]     wrValid;
    logic [NR-1:0]     wrReady;
    logic [NR*AW-1:0]  wrAddr;
    logic [NR*DW-1:0]  wrData;
    logic [NR*BW-1:0]  wrBwN;
    logic [NR-1:0]     rdValid;
    logic [NR-1:0]     rdReady;
    logic [NR*AW-1:0]  rdAddr;
    logic [NR-1:0]     rspValid;
    logic [DW-1:0]     rspData;
    logic              appWrCmd;
    logic [AW-1:0]     appWrAddr;
    logic [DW-1:0]     appWrData;
    logic [BW-1:0]     appWrBwN;
    logic              appRdCmd;
    logic [AW-1:0]     appRdAddr;
    logic [DW-1:0]     appRdData;
    logic              appRdValid;
    logic              underflowErr;
    logic [$clog2(MO):0] outstanding;

    int compared;
    int mismatched;

    logic [AW-1:0] expWAddr [NR];
    logic [DW-1:0] expWData [NR];
    logic [BW-1:0] expWBw   [NR];
    logic          seenActivity;

    qdriip_ui_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BW_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_init_calib_complete (calib),
        .i_req_wr_valid        (wrValid),
        .o_req_wr_ready        (wrReady),
        .i_req_wr_addr         (wrAddr),
        .i_req_wr_data         (wrData),
        .i_req_wr_bw_n         (wrBwN),
        .i_req_rd_valid        (rdValid),
        .o_req_rd_ready        (rdReady),
        .i_req_rd_addr         (rdAddr),
        .o_rsp_rd_valid        (rspValid),
        .o_rsp_rd_data         (rspData),
        .o_app_wr_cmd          (appWrCmd),
        .o_app_wr_addr         (appWrAddr),
        .o_app_wr_data         (appWrData),
        .o_app_wr_bw_n         (appWrBwN),
        .o_app_rd_cmd          (appRdCmd),
        .o_app_rd_addr         (appRdAddr),
        .i_app_rd_data         (appRdData),
        .i_app_rd_valid        (appRdValid),
        .o_rd_underflow_err    (underflowErr),
        .o_rd_outstanding      (outstanding)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] wv, input logic [NR-1:0] rv);
        wrValid = wv;
        rdValid = rv;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering every behaviour in turn.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        calib      = 1'b0;
        wrValid    = '0;
        rdValid    = '0;
        wrAddr     = '0;
        wrData     = '0;
        wrBwN      = '1;
        rdAddr     = '0;
        appRdData  = '0;
        appRdValid = 1'b0;

        expWAddr[0] = 22'h000100; expWData[0] = 72'hA0_1111_2222_3333_4444; expWBw[0] = 8'h0F;
        expWAddr[1] = 22'h000200; expWData[1] = 72'hB1_5555_6666_7777_8888; expWBw[1] = 8'hF0;
        for (int i = 0; i < NR; i++) begin
            wrAddr[i*AW +: AW] = expWAddr[i];
            wrData[i*DW +: DW] = expWData[i];
            wrBwN[i*BW +: BW]  = expWBw[i];
        end
        rdAddr[0 +: AW]  = 22'h000010;
        rdAddr[AW +: AW] = 22'h000020;

        // Reset state.
        repeat (2) nextEdge();
        @(negedge clk);
        checkOutput("rst_app_wr_cmd", appWrCmd, 1'b0);
        checkOutput("rst_app_wr_bw_n", appWrBwN, 8'hFF);
        checkOutput("rst_app_rd_cmd", appRdCmd, 1'b0);
        checkOutput("rst_rsp_valid", rspValid, 2'b00);
        checkOutput("rst_outstanding", outstanding, 5'd0);
        checkOutput("rst_underflow", underflowErr, 1'b0);
        nextEdge();
        rst = 1'b0;

        // Calibration low: nothing may be granted or issued.
        applyStimulus(2'b11, 2'b11);
        seenActivity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seenActivity = seenActivity | (|wrReady) | (|rdReady) | appWrCmd | appRdCmd;
        end
        checkOutput("calib_low_no_activity", seenActivity, 1'b0);
        nextEdge();
        applyStimulus(2'b00, 2'b00);
        calib = 1'b1;
        @(negedge clk);
        checkOutput("calib_idle_app_wr_cmd", appWrCmd, 1'b0);

        // Write round robin: both requesters held valid for six grants.
        nextEdge();
        applyStimulus(2'b11, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wr_rr_grant%0d", k), wrReady, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                checkOutput($sformatf("wr_rr_cmd%0d", k - 1), appWrCmd, 1'b1);
                checkOutput($sformatf("wr_rr_addr%0d", k - 1), appWrAddr, expWAddr[(k - 1) % 2]);
                checkOutput($sformatf("wr_rr_data%0d", k - 1), appWrData, expWData[(k - 1) % 2]);
                checkOutput($sformatf("wr_rr_bw%0d", k - 1), appWrBwN, expWBw[(k - 1) % 2]);
            end
            @(posedge clk);
        end
        #1;
        applyStimulus(2'b00, 2'b00);
        @(negedge clk);
        checkOutput("wr_rr_cmd5", appWrCmd, 1'b1);
        checkOutput("wr_rr_addr5", appWrAddr, expWAddr[1]);
        checkOutput("wr_rr_idle_ready", wrReady, 2'b00);
        nextEdge();
        @(negedge clk);
        checkOutput("wr_idle_cmd", appWrCmd, 1'b0);
        checkOutput("wr_idle_bw_n", appWrBwN, 8'hFF);
        checkOutput("wr_idle_addr_hold", appWrAddr, expWAddr[1]);

        // Back-to-back reads from req0 then req1, data routed in order.
        nextEdge();
        applyStimulus(2'b00, 2'b11);
        @(negedge clk);
        checkOutput("rd_grant_req0", rdReady, 2'b01);
        nextEdge();
        @(negedge clk);
        checkOutput("rd_grant_req1", rdReady, 2'b10);
        checkOutput("rd_cmd_a", appRdCmd, 1'b1);
        checkOutput("rd_addr_a", appRdAddr, 22'h000010);
        nextEdge();
        applyStimulus(2'b00, 2'b00);
        @(negedge clk);
        checkOutput("rd_cmd_b", appRdCmd, 1'b1);
        checkOutput("rd_addr_b", appRdAddr, 22'h000020);
        checkOutput("rd_outstanding_2", outstanding, 5'd2);
        nextEdge();
        appRdValid = 1'b1;
        appRdData  = 72'hD0_DEAD_BEEF_0000_0000;
        nextEdge();
        appRdData  = 72'hD1_CAFE_F00D_1111_1111;
        @(negedge clk);
        checkOutput("rsp0_valid", rspValid, 2'b01);
        checkOutput("rsp0_data", rspData, 72'hD0_DEAD_BEEF_0000_0000);
        checkOutput("rsp0_outstanding", outstanding, 5'd1);
        nextEdge();
        appRdValid = 1'b0;
        @(negedge clk);
        checkOutput("rsp1_valid", rspValid, 2'b10);
        checkOutput("rsp1_data", rspData, 72'hD1_CAFE_F00D_1111_1111);
        checkOutput("rsp1_outstanding", outstanding, 5'd0);
        nextEdge();
        @(negedge clk);
        checkOutput("rsp_idle", rspValid, 2'b00);

        // Fill the tag FIFO with sixteen reads from req0.
        nextEdge();
        applyStimulus(2'b00, 2'b01);
        for (int k = 0; k < MO; k++) begin
            @(negedge clk);
            checkOutput($sformatf("fill_grant%0d", k), rdReady, 2'b01);
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("full_no_grant", rdReady, 2'b00);
        checkOutput("full_outstanding", outstanding, 5'd16);
        nextEdge();
        appRdValid = 1'b1;
        appRdData  = 72'h0F_0F0F_0F0F_0F0F_0F0F;
        @(negedge clk);
        checkOutput("full_pop_cycle_blocked", rdReady, 2'b00);
        nextEdge();
        @(negedge clk);
        checkOutput("after_pop_outstanding", outstanding, 5'd15);
        checkOutput("after_pop_grant", rdReady, 2'b01);
        checkOutput("after_pop_rsp", rspValid, 2'b01);
        nextEdge();
        applyStimulus(2'b00, 2'b00);
        @(negedge clk);
        checkOutput("push_pop_outstanding", outstanding, 5'd15);
        repeat (15) @(posedge clk);
        #1;
        appRdValid = 1'b0;
        @(negedge clk);
        checkOutput("drain_outstanding", outstanding, 5'd0);
        checkOutput("drain_no_underflow", underflowErr, 1'b0);

        // Concurrent write from req1 and read from req0.
        nextEdge();
        wrAddr[AW +: AW] = 22'h000222;
        rdAddr[0 +: AW]  = 22'h000033;
        applyStimulus(2'b10, 2'b01);
        @(negedge clk);
        checkOutput("dual_wr_grant", wrReady, 2'b10);
        checkOutput("dual_rd_grant", rdReady, 2'b01);
        nextEdge();
        applyStimulus(2'b00, 2'b00);
        @(negedge clk);
        checkOutput("dual_wr_cmd", appWrCmd, 1'b1);
        checkOutput("dual_wr_addr", appWrAddr, 22'h000222);
        checkOutput("dual_rd_cmd", appRdCmd, 1'b1);
        checkOutput("dual_rd_addr", appRdAddr, 22'h000033);
        nextEdge();
        appRdValid = 1'b1;
        appRdData  = 72'h33_0000_0000_0000_0033;
        nextEdge();
        appRdValid = 1'b0;
        @(negedge clk);
        checkOutput("dual_rsp_valid", rspValid, 2'b01);
        checkOutput("dual_rsp_data", rspData, 72'h33_0000_0000_0000_0033);

        // Return with nothing outstanding sets the sticky error.
        nextEdge();
        appRdValid = 1'b1;
        nextEdge();
        appRdValid = 1'b0;
        @(negedge clk);
        checkOutput("underflow_set", underflowErr, 1'b1);
        checkOutput("underflow_no_rsp", rspValid, 2'b00);
        checkOutput("underflow_outstanding", outstanding, 5'd0);

        // Reset with four reads from req1 in flight.
        nextEdge();
        applyStimulus(2'b00, 2'b10);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(2'b00, 2'b00);
        @(negedge clk);
        checkOutput("inflight_outstanding", outstanding, 5'd4);
        nextEdge();
        rst = 1'b1;
        nextEdge();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_outstanding", outstanding, 5'd0);
        checkOutput("midrst_underflow", underflowErr, 1'b0);
        checkOutput("midrst_rd_cmd", appRdCmd, 1'b0);
        checkOutput("midrst_wr_addr", appWrAddr, 22'h0);
        checkOutput("midrst_wr_bw_n", appWrBwN, 8'hFF);
        nextEdge();
        appRdValid = 1'b1;
        nextEdge();
        appRdValid = 1'b0;
        @(negedge clk);
        checkOutput("postrst_underflow", underflowErr, 1'b1);
        checkOutput("postrst_no_rsp", rspValid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
